// File: rtl/tl_ul_mem_responder.sv
// TileLink-UL memory responder backed by a 64-bit word array.
// Optional TL_MEM_STALL_EN adds a stall input for arbitrary latency.
module tl_ul_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          MAX_SIZE  = 6
) (
  input  logic        clock,
  input  logic        reset_n,
`ifdef TL_MEM_STALL_EN
  input  logic        stall,
`endif
  output logic        tl_a_ready,
  input  logic        tl_a_valid,
  input  logic [2:0]  tl_a_bits_opcode,
  input  logic [2:0]  tl_a_bits_param,
  input  logic [3:0]  tl_a_bits_size,
  input  logic        tl_a_bits_source,
  input  logic [31:0] tl_a_bits_address,
  input  logic [7:0]  tl_a_bits_mask,
  input  logic [63:0] tl_a_bits_data,
  input  logic        tl_a_bits_corrupt,
  input  logic        tl_d_ready,
  output logic        tl_d_valid,
  output logic [2:0]  tl_d_bits_opcode,
  output logic [1:0]  tl_d_bits_param,
  output logic [3:0]  tl_d_bits_size,
  output logic        tl_d_bits_source,
  output logic        tl_d_bits_sink,
  output logic        tl_d_bits_denied,
  output logic [63:0] tl_d_bits_data,
  output logic        tl_d_bits_corrupt
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    PUT,
    RESP
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [2:0]      op_q;
  logic [3:0]      size_q;
  logic            src_q;
  logic            den_q;
  logic [IW-1:0]   idx_q;
  logic [2:0]      beat_q;
  logic            shown_q;

  logic [63:0]     mem [DEPTH];

  logic            stall_w;
  logic            a_fire;
  logic            d_fire;
  logic            resp;
  logic [31:0]     off;
  logic [29:0]     word_end;
  logic [2:0]      a_last;
  logic            a_put;
  logic            a_den;
  logic            resp_data;
  logic [2:0]      r_last;
  logic [IW-1:0]   rd_idx;
  logic [63:0]     rd_data;
  logic            wr_en;
  logic [IW-1:0]   wr_idx;
  logic            unused;

`ifdef TL_MEM_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  // index of the last beat for a given log2 size
  function automatic logic [2:0] last_of(input logic [3:0] sz);
    if (sz >= 4'd6)      return 3'd7;
    else if (sz == 4'd5) return 3'd3;
    else if (sz == 4'd4) return 3'd1;
    else                 return 3'd0;
  endfunction

  assign unused = ^{tl_a_bits_param, off[2:0]};

  // request decode on the A channel
  assign off      = tl_a_bits_address - BASE_ADDR;
  assign a_last   = last_of(tl_a_bits_size);
  assign word_end = {1'b0, off[31:3]} + {27'd0, a_last};
  assign a_put    = (tl_a_bits_opcode == 3'd0)
                 || (tl_a_bits_opcode == 3'd1);
  assign a_den    = !(a_put || tl_a_bits_opcode == 3'd4)
                 || (tl_a_bits_size > 4'(MAX_SIZE))
                 || (tl_a_bits_address < BASE_ADDR)
                 || (word_end >= 30'(DEPTH));

  assign resp_data = (op_q == 3'd4)
                  || (op_q == 3'd2)
                  || (op_q == 3'd3);
  assign r_last    = resp_data ? last_of(size_q) : 3'd0;

  assign resp       = (state == RESP);
  assign tl_a_ready = reset_n && !stall_w
                   && (state == IDLE || state == PUT);
  assign tl_d_valid = resp && (shown_q || !stall_w);
  assign a_fire     = tl_a_valid && tl_a_ready;
  assign d_fire     = tl_d_valid && tl_d_ready;

  assign rd_idx  = idx_q + IW'(beat_q);
  assign rd_data = mem[rd_idx];

  assign tl_d_bits_opcode  = (resp && resp_data) ? 3'd1 : 3'd0;
  assign tl_d_bits_param   = 2'd0;
  assign tl_d_bits_size    = resp ? size_q : 4'd0;
  assign tl_d_bits_source  = resp && src_q;
  assign tl_d_bits_sink    = 1'b0;
  assign tl_d_bits_denied  = resp && den_q;
  assign tl_d_bits_data    = (resp && resp_data && !den_q)
                           ? rd_data : 64'd0;
  assign tl_d_bits_corrupt = resp && resp_data && den_q;

  // next-state selection
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (a_fire) begin
          if (a_put && a_last != 3'd0) state_nx = PUT;
          else                         state_nx = RESP;
        end
      end
      PUT: begin
        if (a_fire && beat_q == last_of(size_q))
          state_nx = RESP;
      end
      RESP: begin
        if (d_fire && beat_q == r_last)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // write port: first beat in IDLE, later beats in PUT
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    unique case (1'b1)
      (state == IDLE): begin
        wr_en  = a_fire && a_put && !a_den
              && !tl_a_bits_corrupt;
        wr_idx = off[IW+2:3];
      end
      (state == PUT): begin
        wr_en  = a_fire && !den_q && !tl_a_bits_corrupt;
        wr_idx = idx_q + IW'(beat_q);
      end
      default: ;
    endcase
  end

  // state, request context and beat counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      op_q    <= '0;
      size_q  <= '0;
      src_q   <= 1'b0;
      den_q   <= 1'b0;
      idx_q   <= '0;
      beat_q  <= '0;
      shown_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && a_fire) begin
        op_q   <= tl_a_bits_opcode;
        size_q <= tl_a_bits_size;
        src_q  <= tl_a_bits_source;
        den_q  <= a_den;
        idx_q  <= off[IW+2:3];
        beat_q <= (a_put && a_last != 3'd0) ? 3'd1 : 3'd0;
      end else if (state == PUT && a_fire) begin
        beat_q <= (beat_q == last_of(size_q))
                ? 3'd0 : beat_q + 3'd1;
      end else if (d_fire) begin
        beat_q <= (beat_q == r_last) ? 3'd0 : beat_q + 3'd1;
      end
      if (d_fire)          shown_q <= 1'b0;
      else if (tl_d_valid) shown_q <= 1'b1;
    end
  end

  // byte-masked memory write, contents survive reset
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (tl_a_bits_mask[b])
          mem[wr_idx][8*b +: 8] <= tl_a_bits_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_tl_ul_mem_responder.sv
// Scoreboard bench for tl_ul_mem_responder.
// Stimulus pushes expected D beats; a monitor pops and compares.
module tb_tl_ul_mem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;

  logic        clock;
  logic        reset_n;
  logic        tl_a_ready;
  logic        tl_a_valid;
  logic [2:0]  tl_a_bits_opcode;
  logic [2:0]  tl_a_bits_param;
  logic [3:0]  tl_a_bits_size;
  logic        tl_a_bits_source;
  logic [31:0] tl_a_bits_address;
  logic [7:0]  tl_a_bits_mask;
  logic [63:0] tl_a_bits_data;
  logic        tl_a_bits_corrupt;
  logic        tl_d_ready;
  logic        tl_d_valid;
  logic [2:0]  tl_d_bits_opcode;
  logic [1:0]  tl_d_bits_param;
  logic [3:0]  tl_d_bits_size;
  logic        tl_d_bits_source;
  logic        tl_d_bits_sink;
  logic        tl_d_bits_denied;
  logic [63:0] tl_d_bits_data;
  logic        tl_d_bits_corrupt;

  tl_ul_mem_responder dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .tl_a_ready        (tl_a_ready),
    .tl_a_valid        (tl_a_valid),
    .tl_a_bits_opcode  (tl_a_bits_opcode),
    .tl_a_bits_param   (tl_a_bits_param),
    .tl_a_bits_size    (tl_a_bits_size),
    .tl_a_bits_source  (tl_a_bits_source),
    .tl_a_bits_address (tl_a_bits_address),
    .tl_a_bits_mask    (tl_a_bits_mask),
    .tl_a_bits_data    (tl_a_bits_data),
    .tl_a_bits_corrupt (tl_a_bits_corrupt),
    .tl_d_ready        (tl_d_ready),
    .tl_d_valid        (tl_d_valid),
    .tl_d_bits_opcode  (tl_d_bits_opcode),
    .tl_d_bits_param   (tl_d_bits_param),
    .tl_d_bits_size    (tl_d_bits_size),
    .tl_d_bits_source  (tl_d_bits_source),
    .tl_d_bits_sink    (tl_d_bits_sink),
    .tl_d_bits_denied  (tl_d_bits_denied),
    .tl_d_bits_data    (tl_d_bits_data),
    .tl_d_bits_corrupt (tl_d_bits_corrupt)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  size;
    logic        src;
    logic        den;
    logic [63:0] data;
    logic        cor;
  } exp_t;

  exp_t        sb[$];
  exp_t        act;
  exp_t        e;
  int          n_chk;
  int          n_fail;
  bit          tog;
  logic [3:0]  pat;
  int          k;
  logic [63:0] ex [8];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // D-ready driver: constant 1 or the 1,0,0,1 pattern
  initial begin
    pat = 4'b1001;
    k   = 0;
    forever begin
      @(posedge clock);
      #1;
      if (tog) begin
        tl_d_ready = pat[k];
        k = (k + 1) % 4;
      end else begin
        tl_d_ready = 1'b1;
      end
    end
  end

  // monitor: compare every presented D beat, pop on fire
  always @(negedge clock) begin
    if (reset_n && tl_d_valid) begin
      act = '{tl_d_bits_opcode, tl_d_bits_size,
              tl_d_bits_source, tl_d_bits_denied,
              tl_d_bits_data, tl_d_bits_corrupt};
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_d actual=%h required=none", act);
      end else begin
        e = sb[0];
        if (act !== e || tl_d_bits_param !== 2'd0
            || tl_d_bits_sink !== 1'b0) begin
          n_fail++;
          $display("FAIL d_beat actual=%h required=%h p=%0d s=%0d",
                   act, e, tl_d_bits_param, tl_d_bits_sink);
        end
        if (tl_d_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] r);
    n_chk++;
    if (a !== r) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, a, r);
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [3:0] sz,
                      input logic src, input logic den,
                      input logic [63:0] d, input logic cor);
    exp_t x;
    x = '{op, sz, src, den, d, cor};
    sb.push_back(x);
  endtask

  // drive one A beat; starts and ends at posedge+1
  task automatic a_send(input logic [2:0] op, input logic [3:0] sz,
                        input logic src, input logic [31:0] addr,
                        input logic [7:0] m, input logic [63:0] d);
    bit ok;
    ok = 0;
    tl_a_bits_opcode  = op;
    tl_a_bits_size    = sz;
    tl_a_bits_source  = src;
    tl_a_bits_address = addr;
    tl_a_bits_mask    = m;
    tl_a_bits_data    = d;
    tl_a_valid        = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (tl_a_ready) begin
        ok = 1;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL a_ready_timeout actual=0 required=1");
    end
    @(posedge clock);
    #1;
    tl_a_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_timeout actual=%0d required=0",
               sb.size());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic lat_chk();
    chk("d_latency", {63'd0, tl_d_valid}, 64'd1);
  endtask

  task automatic put1(input logic [2:0] op, input logic src,
                      input logic [31:0] addr, input logic [7:0] m,
                      input logic [63:0] d, input logic den);
    push(3'd0, 4'd3, src, den, 64'd0, 1'b0);
    a_send(op, 4'd3, src, addr, m, d);
    lat_chk();
    drain();
  endtask

  task automatic put8(input logic [31:0] addr,
                      input logic [63:0] base, input logic src);
    push(3'd0, 4'd6, src, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 8; i++)
      a_send(3'd0, 4'd6, src, addr, 8'hFF, base + 64'(i));
    lat_chk();
    drain();
  endtask

  // Get; expected words come from ex[]
  task automatic get(input logic [3:0] sz, input logic [31:0] addr,
                     input logic src, input logic den, input int n);
    for (int i = 0; i < n; i++)
      push(3'd1, sz, src, den, den ? 64'd0 : ex[i], den);
    a_send(3'd4, sz, src, addr, 8'hFF, 64'd0);
    lat_chk();
    drain();
  endtask

  initial begin
    n_chk             = 0;
    n_fail            = 0;
    tog               = 0;
    reset_n           = 1'b0;
    tl_d_ready        = 1'b1;
    tl_a_valid        = 1'b0;
    tl_a_bits_opcode  = '0;
    tl_a_bits_param   = '0;
    tl_a_bits_size    = '0;
    tl_a_bits_source  = '0;
    tl_a_bits_address = '0;
    tl_a_bits_mask    = '0;
    tl_a_bits_data    = '0;
    tl_a_bits_corrupt = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_a_ready", {63'd0, tl_a_ready}, 64'd0);
    chk("rst_d_valid", {63'd0, tl_d_valid}, 64'd0);
    chk("rst_d_data", tl_d_bits_data, 64'd0);
    chk("rst_d_misc",
        {50'd0, tl_d_bits_opcode, tl_d_bits_param, tl_d_bits_size,
         tl_d_bits_source, tl_d_bits_sink, tl_d_bits_denied,
         tl_d_bits_corrupt}, 64'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("idle_a_ready", {63'd0, tl_a_ready}, 64'd1);

    // single-beat put then get, source 1
    put1(3'd0, 1'b1, BASE + 32'h10, 8'hFF,
         64'h1122334455667788, 1'b0);
    ex[0] = 64'h1122334455667788;
    get(4'd3, BASE + 32'h10, 1'b1, 1'b0, 1);

    // partial put over an all-ones word
    put1(3'd0, 1'b0, BASE + 32'h18, 8'hFF, '1, 1'b0);
    put1(3'd1, 1'b0, BASE + 32'h18, 8'h0F,
         64'hAAAAAAAA_BBBBBBBB, 1'b0);
    ex[0] = 64'hFFFFFFFF_BBBBBBBB;
    get(4'd3, BASE + 32'h18, 1'b0, 1'b0, 1);

    // 8-beat burst write and read back
    put8(BASE, 64'd0, 1'b1);
    for (int i = 0; i < 8; i++) ex[i] = 64'(i);
    get(4'd6, BASE, 1'b1, 1'b0, 8);

    // burst read with D backpressure 1,0,0,1
    tog = 1;
    get(4'd6, BASE, 1'b0, 1'b0, 8);
    tog = 0;

    // denied requests
    get(4'd3, BASE - 32'd8, 1'b0, 1'b1, 1);
    get(4'd3, BASE + 32'(DEPTH * 8), 1'b1, 1'b1, 1);
    push(3'd0, 4'd3, 1'b0, 1'b1, 64'd0, 1'b0);
    a_send(3'd5, 4'd3, 1'b0, BASE + 32'h10, 8'hFF, 64'hDEAD);
    lat_chk();
    drain();
    put1(3'd0, 1'b0, BASE + 32'(DEPTH * 8), 8'hFF,
         64'hDEAD_BEEF, 1'b1);
    ex[0] = 64'd0;
    get(4'd3, BASE, 1'b0, 1'b0, 1);
    ex[0] = 64'd2;
    get(4'd3, BASE + 32'h10, 1'b0, 1'b0, 1);

    // reset during beat 4 of an 8-beat put
    put8(BASE + 32'h100, 64'hF0, 1'b0);
    for (int i = 0; i < 3; i++)
      a_send(3'd0, 4'd6, 1'b0, BASE + 32'h100, 8'hFF,
             64'hA0 + 64'(i));
    tl_a_bits_data = 64'hA3;
    tl_a_valid     = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_d_valid", {63'd0, tl_d_valid}, 64'd0);
    chk("mid_rst_a_ready", {63'd0, tl_a_ready}, 64'd0);
    @(posedge clock);
    #1;
    tl_a_valid = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    chk("post_rst_a_ready", {63'd0, tl_a_ready}, 64'd1);
    @(posedge clock);
    #1;
    ex = '{64'hA0, 64'hA1, 64'hA2, 64'hF3,
           64'hF4, 64'hF5, 64'hF6, 64'hF7};
    get(4'd6, BASE + 32'h100, 1'b0, 1'b0, 8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_ul_mem_responder.md
Name: tl_ul_mem_responder

Overview:
- TileLink-UL responder (slave) that terminates the tile's TL master port in formal and simulation harnesses.
- Backs requests with a small 64-bit-wide memory array.
- Accepts Get, PutFullData and PutPartialData, including multi-beat bursts; returns AccessAck or AccessAckData on the D channel.
- All other opcodes and out-of-range addresses are answered with denied responses, so the core always sees protocol-legal traffic.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- DEPTH, 1024, number of 64-bit words; power of two.
- MAX_SIZE, 6, largest legal log2(bytes) per request; larger sizes are denied.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- tl_a_ready  out  1  A-channel ready.
- tl_a_valid  in  1  A-channel valid.
- tl_a_bits_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get; others unsupported.
- tl_a_bits_param  in  3  ignored.
- tl_a_bits_size  in  4  log2 bytes.
- tl_a_bits_source  in  1  request ID, echoed on D.
- tl_a_bits_address  in  32  byte address.
- tl_a_bits_mask  in  8  byte lanes.
- tl_a_bits_data  in  64  write data.
- tl_a_bits_corrupt  in  1  when set, that beat is not written.
- tl_d_ready  in  1  D-channel ready.
- tl_d_valid  out  1  D-channel valid.
- tl_d_bits_opcode  out  3  0=AccessAck, 1=AccessAckData.
- tl_d_bits_param  out  2  always 0.
- tl_d_bits_size  out  4  echo of the request size.
- tl_d_bits_source  out  1  echo of the request source.
- tl_d_bits_sink  out  1  always 0.
- tl_d_bits_denied  out  1  request refused.
- tl_d_bits_data  out  64  read data.
- tl_d_bits_corrupt  out  1  equals denied on AccessAckData, 0 on AccessAck.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; tl_d_valid=0; tl_a_ready=0 while reset_n is low; all tl_d_bits_*=0; beat counters=0. Memory contents are not reset.
- Beats per request: beats = (size>3) ? 1<<(size-3) : 1. The beat counter is 3 bits wide to cover MAX_SIZE=6.
- Word index: (address-BASE_ADDR)>>3, plus the beat number.
- Denied: opcode not in {0,1,4}, size>MAX_SIZE, address below BASE_ADDR, or any beat index >= DEPTH. A denied request never touches memory.
- States:
  - IDLE: tl_a_ready=1. On A fire, latch opcode, size, source, base index and denied.
    - Put with beats>1 -> PUT.
    - Any other request -> RESP, with tl_d_valid=1 in the next cycle (1-cycle latency).
  - PUT: tl_a_ready=1. Each A fire writes one beat, byte-masked by tl_a_bits_mask, at index+beat. After the last beat -> RESP.
    - During PUT, the opcode, size and source of later beats are not checked.
  - RESP: tl_a_ready=0; tl_d_valid=1.
    - Put: one AccessAck beat; when it fires -> IDLE.
    - Get: `beats` AccessAckData beats, one word per beat; the beat counter advances only on D fire; after the last fire -> IDLE.
    - Unsupported opcode: AccessAckData if the request carried data semantics (opcodes 2, 3), otherwise AccessAck (opcode 5); denied=1; same beat count as a Get for AckData.
- Put data is written in the cycle A fires (first beat in IDLE, later beats in PUT). A Get issued right after a Put returns the new data.
- tl_d_bits_* are stable while tl_d_valid=1 and tl_d_ready=0. tl_d_valid never drops without a fire.
- Denied AccessAckData returns data=0, corrupt=1.
- Non-denied reads of memory never written since power-up return X in simulation and an unconstrained value in formal.
- Only one request is outstanding at a time; A and D never fire in the same cycle.
- Reset mid-burst: abandons the transaction; the memory keeps every beat already written.

Optional Feature:
- Macro TL_MEM_STALL_EN.
- When defined: adds input `stall` (1 bit).
  - While stall=1, tl_a_ready is forced to 0.
  - In RESP, tl_d_valid is not raised, or the next beat is not presented, until stall=0.
  - Once tl_d_valid=1, stall does not retract it.
  - Lets formal explore arbitrary responder latency.
- When undefined: no port; behaviour as above, with fixed 1-cycle latency.

Test Plan:
- PutFull size=3, addr=BASE+0x10, data=64'h1122334455667788, mask=FF; then Get size=3, same address -> one AccessAck with source echoed; then AccessAckData with that data, denied=0, d_valid one cycle after A fire.
- PutPartial mask=8'h0F, data=64'hAAAAAAAA_BBBBBBBB onto a word holding all-ones -> a following Get returns 64'hFFFFFFFF_BBBBBBBB.
- PutFull size=6 (8 beats, data=beat#) at BASE; then Get size=6 -> exactly one AccessAck after beat 8; then 8 AckData beats with data 0..7 in order, size=6 on every beat.
- Get size=6 with tl_d_ready toggling 1,0,0,1 -> no beat lost or duplicated; D bits held while stalled.
- Get at BASE-8, Get at BASE+DEPTH*8, and opcode 5 -> denied=1; the two Gets return data=0, corrupt=1; opcode 5 returns AccessAck with corrupt=0; memory unchanged.
- Assert reset_n low during beat 4 of an 8-beat Put -> d_valid=0 immediately; a_ready=1 after release; beats 1-3 readable, beats 4-8 unchanged.
